// File: rtl/lbp_mem_host.sv
`default_nettype none
// ============================================================================
//  Module      : lbp_mem_host
//  Description : Memory-side responder for the LBP engine. It loads an 8x8
//                grey image, serves the engine's pixel reads with one cycle of
//                latency, and captures the engine's result writes. When the
//                engine finishes, it streams the result image out through a
//                valid/ready port. It also flags border, range, count and
//                timeout errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module lbp_mem_host #(
   parameter int IMG_W   = 8,
   parameter int ADDR_W  = 6,
   parameter int GRAY_W  = 14,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              ld_valid,
   input  logic [7:0]        ld_data,
   output logic              ld_ready,
   output logic              eng_rst,
   input  logic [ADDR_W-1:0] gray_addr,
   input  logic              gray_req,
   output logic [GRAY_W-1:0] gray_data,
   input  logic [ADDR_W-1:0] lbp_addr,
   input  logic              lbp_write,
   input  logic [GRAY_W-1:0] lbp_data,
   input  logic              finish,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic              done,
   output logic              err_border,
   output logic              err_range,
   output logic              err_count,
   output logic              err_timeout
);

   localparam int                DEPTH     = IMG_W * IMG_W;
   localparam int                TO_W      = $clog2(TIMEOUT);
   localparam logic [6:0]        WR_EXPECT = 7'((IMG_W - 2) * (IMG_W - 2));
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_SERVE   = 3'd2;
   localparam logic [2:0] S_READOUT = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [ADDR_W-1:0] idx;
   logic [TO_W-1:0]   to_cnt;
   logic [6:0]        wr_cnt;
   logic [6:0]        wr_cnt_nxt;
   logic [7:0]        gray_ram [DEPTH];
   logic [7:0]        res_ram  [DEPTH];

   logic ld_beat;
   logic rd_beat;
   logic write_en;
   logic timeout_hit;
   logic border_hit;
   logic range_hit;

   assign ld_beat     = (state == S_LOAD) && ld_valid;
   assign rd_beat     = (state == S_READOUT) && rd_ready;
   assign write_en    = (state == S_SERVE) && lbp_write;
   assign timeout_hit = (state == S_SERVE) && !finish && (to_cnt == TO_LAST);
   assign border_hit  = (lbp_addr[2:0] == 3'd0) || (lbp_addr[2:0] == 3'd7) ||
                        (lbp_addr[5:3] == 3'd0) || (lbp_addr[5:3] == 3'd7);
   assign range_hit   = |lbp_data[GRAY_W-1:8];
   // Count including a write in the current cycle, so a finish that coincides
   // with the last write sees the committed total.
   assign wr_cnt_nxt  = (write_en && (wr_cnt != 7'h7f)) ? wr_cnt + 7'd1 : wr_cnt;

   assign rd_addr = idx;
   assign rd_data = res_ram[idx];

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start) state_nxt = S_LOAD;
         S_LOAD:    if (ld_beat && (idx == LAST_IDX)) state_nxt = S_SERVE;
         S_SERVE:   if (finish || timeout_hit) state_nxt = S_READOUT;
         S_READOUT: if (rd_beat && (idx == LAST_IDX)) state_nxt = S_DONE;
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // State-decoded outputs; the engine runs only while SERVE is active
   always_comb begin
      ld_ready = (state == S_LOAD);
      eng_rst  = (state != S_SERVE);
      rd_valid = (state == S_READOUT);
      done     = (state == S_DONE);
   end

   // Index, timeout and write counters plus the registered read data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx       <= '0;
         to_cnt    <= '0;
         wr_cnt    <= '0;
         gray_data <= '0;
      end else begin
         if (state == S_IDLE)
            idx <= '0;
         else if (ld_beat || rd_beat)
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;

         to_cnt <= (state == S_SERVE) ? to_cnt + 1'b1 : '0;
         wr_cnt <= (state == S_SERVE) ? wr_cnt_nxt : '0;

         if ((state == S_SERVE) && gray_req)
            gray_data <= {{(GRAY_W-8){1'b0}}, gray_ram[gray_addr]};
      end
   end

   // Sticky error flags, cleared when a new image load begins
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_border  <= 1'b0;
         err_range   <= 1'b0;
         err_count   <= 1'b0;
         err_timeout <= 1'b0;
      end else if ((state == S_IDLE) && start) begin
         err_border  <= 1'b0;
         err_range   <= 1'b0;
         err_count   <= 1'b0;
         err_timeout <= 1'b0;
      end else if (state == S_SERVE) begin
         if (write_en && border_hit)          err_border  <= 1'b1;
         if (write_en && range_hit)           err_range   <= 1'b1;
         if (finish && (wr_cnt_nxt != WR_EXPECT)) err_count <= 1'b1;
         if (timeout_hit)                     err_timeout <= 1'b1;
      end
   end

   // Image and result storage; loading a pixel also clears its result slot
   always_ff @(posedge clk) begin
      if (ld_beat) begin
         gray_ram[idx] <= ld_data;
         res_ram[idx]  <= 8'h00;
      end else if (write_en) begin
         res_ram[lbp_addr] <= lbp_data[7:0];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lbp_mem_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lbp_mem_host
//  Description : Self-checking bench for lbp_mem_host with a scoreboard for
//                pixel reads and result readout beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lbp_mem_host;

   localparam int ADDR_W  = 6;
   localparam int GRAY_W  = 14;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic              ld_valid;
   logic [7:0]        ld_data;
   logic              ld_ready;
   logic              eng_rst;
   logic [ADDR_W-1:0] gray_addr;
   logic              gray_req;
   logic [GRAY_W-1:0] gray_data;
   logic [ADDR_W-1:0] lbp_addr;
   logic              lbp_write;
   logic [GRAY_W-1:0] lbp_data;
   logic              finish;
   logic              rd_valid;
   logic              rd_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data;
   logic              done;
   logic              err_border;
   logic              err_range;
   logic              err_count;
   logic              err_timeout;

   lbp_mem_host dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_ready    (ld_ready),
      .eng_rst     (eng_rst),
      .gray_addr   (gray_addr),
      .gray_req    (gray_req),
      .gray_data   (gray_data),
      .lbp_addr    (lbp_addr),
      .lbp_write   (lbp_write),
      .lbp_data    (lbp_data),
      .finish      (finish),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .done        (done),
      .err_border  (err_border),
      .err_range   (err_range),
      .err_count   (err_count),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   int errors   = 0;
   int checks   = 0;
   int done_cnt = 0;

   logic [GRAY_W-1:0] gq [$];
   logic [13:0]       rq [$];
   logic              gray_pend = 1'b0;
   logic [7:0]        exp_res [64];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops expected read data and readout beats as the DUT presents them
   always @(negedge clk) begin
      if (gray_pend) begin
         if (gq.size() == 0) begin
            checks++; errors++;
            $display("FAIL gray_sb: unexpected read response %0h", gray_data);
         end else begin
            chk("gray_data", 32'(gray_data), 32'(gq.pop_front()));
         end
      end
      gray_pend = gray_req;
      if (rd_valid && rd_ready) begin
         if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_sb: unexpected beat addr %0d data %0h", rd_addr, rd_data);
         end else begin
            chk("rd_beat", 32'({rd_addr, rd_data}), 32'(rq.pop_front()));
         end
      end
      if (done) done_cnt++;
   end

   task automatic load_image(input logic [7:0] pattern);
      start = 1'b1;
      tick();
      start = 1'b0;
      ld_valid = 1'b1;
      for (int a = 0; a < 64; a++) begin
         ld_data = 8'(a) ^ pattern;
         exp_res[a] = 8'h00;
         if (a == 63) chk("load_eng_rst", 32'(eng_rst), 32'd1);
         tick();
      end
      ld_valid = 1'b0;
      chk("serve_eng_rst", 32'(eng_rst), 32'd0);
   endtask

   task automatic lbp_wr(input int addr, input logic [GRAY_W-1:0] data, input logic fin);
      lbp_addr  = 6'(addr);
      lbp_data  = data;
      lbp_write = 1'b1;
      finish    = fin;
      exp_res[addr] = data[7:0];
      tick();
      lbp_write = 1'b0;
      finish    = 1'b0;
   endtask

   task automatic do_finish();
      finish = 1'b1;
      tick();
      finish = 1'b0;
   endtask

   task automatic readout_all();
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < 64; i++) rq.push_back({6'(i), exp_res[i]});
      rd_ready = 1'b1;
      repeat (70) tick();
      rd_ready = 1'b0;
      chk("rd_drained", 32'(rq.size()), 32'd0);
      chk("done_pulse", 32'(done_cnt - d0), 32'd1);
      chk("back_idle", 32'({rd_valid, eng_rst, ld_ready}), 32'b010);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_data = '0;
      gray_addr = '0; gray_req = 1'b0; lbp_addr = '0; lbp_write = 1'b0;
      lbp_data = '0; finish = 1'b0; rd_ready = 1'b0;
      repeat (3) tick();
      chk("rst_outputs", 32'({eng_rst, ld_ready, rd_valid, done}), 32'b1000);
      chk("rst_gray", 32'(gray_data), 32'd0);
      chk("rst_errs", 32'({err_border, err_range, err_count, err_timeout}), 32'd0);
      reset_n = 1'b1;
      tick();

      // Reset in the middle of a load aborts to IDLE
      start = 1'b1; tick(); start = 1'b0;
      ld_valid = 1'b1;
      for (int a = 0; a < 20; a++) begin ld_data = 8'(a); tick(); end
      chk("mid_load_ready", 32'(ld_ready), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_ready", 32'(ld_ready), 32'd0);
      chk("abort_eng_rst", 32'(eng_rst), 32'd1);
      ld_valid = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      chk("idle_ready", 32'(ld_ready), 32'd0);

      // Pixel reads with one-cycle latency, then hold
      load_image(8'h00);
      foreach (gq[i]) gq.delete(i);
      gray_req = 1'b1;
      gray_addr = 6'd0;  gq.push_back(14'd0);  tick();
      gray_addr = 6'd63; gq.push_back(14'd63); tick();
      gray_addr = 6'd36; gq.push_back(14'd36); tick();
      gray_addr = 6'd9;  gq.push_back(14'd9);  tick();
      gray_req = 1'b0;
      gray_addr = 6'd50;
      repeat (3) tick();
      chk("gray_hold", 32'(gray_data), 32'd9);

      // 36 interior writes with concurrent reads, then finish
      for (int r = 1; r < 7; r++)
         for (int c = 1; c < 7; c++) begin
            gray_req  = 1'b1;
            gray_addr = 6'(63 - (r * 8 + c));
            gq.push_back(14'(63 - (r * 8 + c)));
            lbp_wr(r * 8 + c, 14'(r * 8 + c), 1'b0);
         end
      gray_req = 1'b0;
      do_finish();
      chk("t3_errs", 32'({err_border, err_range, err_count, err_timeout}), 32'd0);
      chk("t3_readout", 32'({rd_valid, eng_rst}), 32'b11);
      readout_all();
      chk("gray_sb_empty", 32'(gq.size()), 32'd0);

      // Border and range errors; the border write is stored
      load_image(8'h3C);
      lbp_wr(0, 14'h100, 1'b0);
      chk("t4_border", 32'(err_border), 32'd1);
      chk("t4_range", 32'(err_range), 32'd1);
      do_finish();
      chk("t4_count", 32'(err_count), 32'd1);
      readout_all();

      // 36th write coincides with finish: count is satisfied
      load_image(8'h00);
      chk("t5_cleared", 32'({err_border, err_range, err_count, err_timeout}), 32'd0);
      for (int k = 0; k < 36; k++) begin
         int a;
         a = (k / 6 + 1) * 8 + (k % 6 + 1);
         lbp_wr(a, 14'(8'(a) ^ 8'hA5), (k == 35));
      end
      chk("t5a_errs", 32'({err_border, err_range, err_count, err_timeout}), 32'd0);
      chk("t5a_readout", 32'(rd_valid), 32'd1);
      readout_all();

      // Only 35 writes before a bare finish: count error
      load_image(8'h00);
      for (int k = 0; k < 35; k++) begin
         int a;
         a = (k / 6 + 1) * 8 + (k % 6 + 1);
         lbp_wr(a, 14'(8'(a) ^ 8'h5A), 1'b0);
      end
      do_finish();
      chk("t5b_count", 32'(err_count), 32'd1);
      chk("t5b_other", 32'({err_border, err_range, err_timeout}), 32'd0);
      readout_all();

      // Timeout: no finish for TIMEOUT serve cycles
      load_image(8'h00);
      lbp_wr(0, 14'h55, 1'b0);
      repeat (4094) tick();
      chk("t6_pre_serve", 32'({eng_rst, err_timeout, rd_valid}), 32'b000);
      tick();
      chk("t6_timeout", 32'(err_timeout), 32'd1);
      chk("t6_readout", 32'({rd_valid, eng_rst}), 32'b11);
      chk("t6_count", 32'(err_count), 32'd0);
      chk("t6_border", 32'(err_border), 32'd1);
      for (int s = 0; s < 5; s++) begin
         tick();
         chk("t6_stall", 32'({rd_valid, rd_addr, rd_data}), 32'({1'b1, 6'd0, 8'h55}));
      end
      readout_all();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
